// File: rtl/ahb_slave_regfile.sv
// AHB-Lite slave register bank: NUM_REGS x 32-bit words, byte/halfword/word strobes, WAIT_CYCLES wait states per OKAY data phase.
// Define AHB_SLV_ERR_EN to answer illegal transfers with the two-cycle ERROR response instead of a silent zero-wait OKAY.
module ahb_slave_regfile #(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);
    localparam int unsigned IDX_W    = $clog2(NUM_REGS);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

`ifdef AHB_SLV_ERR_EN
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA} state_t;
`endif

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         off_q, off_d;
    logic [2:0]         size_q, size_d;
    logic               wr_q, wr_d;
    logic               legal_q, legal_d;
    logic [31:0]        regs_q [NUM_REGS];

    logic               accept;
    logic               legal_in;
    logic               aligned;
    logic               wr_en;
    logic [3:0]         strb;
    logic               unused_bits;

    assign unused_bits = ^{HADDR[31:12], HTRANS[0]};

    // A new address phase is only taken while this slave is not stalling the bus.
    assign accept  = HSEL & HTRANS[1] & HREADY & HREADYOUT;
    assign aligned = (HSIZE == 3'd0) ||
                     ((HSIZE == 3'd1) && !HADDR[0]) ||
                     ((HSIZE == 3'd2) && (HADDR[1:0] == 2'b00));
    assign legal_in = ({22'd0, HADDR[11:2]} < NUM_REGS) && (HSIZE <= 3'd2) && aligned;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        wr_d    = wr_q;
        legal_d = legal_q;
        if (accept) begin
            idx_d   = HADDR[2 +: IDX_W];
            off_d   = HADDR[1:0];
            size_d  = HSIZE;
            wr_d    = HWRITE;
            legal_d = legal_in;
        end
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
`ifdef AHB_SLV_ERR_EN
            S_ERR1: state_d = S_ERR2;
`endif
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (!legal_in) begin
`ifdef AHB_SLV_ERR_EN
                        state_d = S_ERR1;
`else
                        state_d = S_IDLE;
`endif
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            off_q   <= 2'b00;
            size_q  <= 3'd0;
            wr_q    <= 1'b0;
            legal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
            wr_q    <= wr_d;
            legal_q <= legal_d;
        end
    end

    always_comb begin
        strb = 4'b0000;
        case (size_q)
            3'd0:    strb = 4'b0001 << off_q;
            3'd1:    strb = off_q[1] ? 4'b1100 : 4'b0011;
            3'd2:    strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
    end

    assign wr_en = (state_q == S_DATA) && wr_q && legal_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) regs_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    // Read straight from the array so a read right after a write sees the committed value.
    assign HRDATA = ((state_q == S_DATA) && !wr_q && legal_q) ? regs_q[idx_q] : 32'd0;

`ifdef AHB_SLV_ERR_EN
    assign HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
    assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
`else
    assign HREADYOUT = (state_q != S_WAIT);
    assign HRESP     = 1'b0;
`endif

endmodule

// File: doc/ahb_slave_regfile.md
Name: ahb_slave_regfile

Overview:
AHB-Lite slave register bank. It sits directly downstream of the team's AHB master and consumes its NONSEQ/SEQ write and read transfers. It stores NUM_REGS 32-bit words and supports byte, halfword and word write strobing. Wait-state insertion is programmable, so master stall handling can be exercised.

Parameters:
NUM_REGS, 16, number of 32-bit registers; power of two, 2..256.
WAIT_CYCLES, 0, HREADYOUT-low cycles inserted in every OKAY data phase; 0..15.
RESET_VAL, 32'h0000_0000, reset value of every register.

Ports:
HCLK  in  1  bus clock; all state changes on the rising edge.
HRESETn  in  1  asynchronous, active-low reset.
HSEL  in  1  slave select from the decoder.
HADDR  in  32  transfer address; bits [11:0] are the offset into a 4 KB window.
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
HWRITE  in  1  1 = write, 0 = read.
HSIZE  in  3  0 byte, 1 halfword, 2 word.
HWDATA  in  32  write data, valid in the data phase.
HREADY  in  1  bus-level ready; an address phase is accepted only when high.
HREADYOUT  out  1  slave ready; low = wait state.
HRESP  out  1  0 OKAY, 1 ERROR.
HRDATA  out  32  read data, valid in the data phase when HREADYOUT=1.

Behaviour:
- Reset, asynchronous on HRESETn low:
  - All registers = RESET_VAL.
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - Wait counter = 0; FSM = IDLE; latched address-phase info cleared.
  - A transfer in flight when reset asserts is dropped: no write commits.
- Accept condition (address phase): HSEL & HTRANS[1] & HREADY. On the next clock edge the slave latches:
  - index = HADDR[2 +: log2(NUM_REGS)]
  - byte offset = HADDR[1:0]
  - HSIZE, HWRITE
  - a legality flag
- Legal transfer:
  - HADDR[11:2] < NUM_REGS;
  - HSIZE <= 2;
  - naturally aligned: halfword needs HADDR[0]=0; word needs HADDR[1:0]=0.
- IDLE or BUSY with HSEL high, or HSEL low:
  - no access; the next cycle is a zero-wait OKAY (HREADYOUT=1, HRESP=0).
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE -> WAIT: on accept of a legal transfer with WAIT_CYCLES>0.
  - IDLE -> DATA: on accept of a legal transfer with WAIT_CYCLES=0.
  - WAIT: HREADYOUT=0, HRESP=0; counter counts WAIT_CYCLES-1 down to 0, then -> DATA.
  - DATA: HREADYOUT=1, HRESP=0.
    - Write: commits at the end of this cycle, using HWDATA sampled in this cycle.
    - Read: HRDATA is driven in this cycle.
    - Exit: to WAIT, DATA or ERR1 if a new transfer is accepted in the same cycle (pipelined); otherwise to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1. Any new address phase accepted in ERR2 is processed normally.
- Write strobes, derived from the latched size and offset:
  - byte: lane HADDR[1:0] only;
  - halfword: lanes {1,0} or {3,2} according to HADDR[1];
  - word: all four lanes.
  - Unselected lanes retain their value.
- Read data:
  - HRDATA = register[index], full word regardless of HSIZE.
  - Driven combinationally from the register array during the data phase with HREADYOUT=1; 0 otherwise.
  - Consequence: a read whose data phase directly follows a write to the same index returns the newly written value. No stale data.
- Throughput: back-to-back pipelined transfers with WAIT_CYCLES=0 complete one per cycle.
- HREADY low during an address phase: that phase is not accepted; the slave holds its current state.

Optional Feature:
AHB_SLV_ERR_EN
- Defined: illegal transfers take the two-cycle ERROR path (ERR1 -> ERR2). Writes are suppressed and HRDATA=0.
- Undefined: illegal transfers complete as zero-wait OKAY. Writes are discarded, reads return 0, and the ERR states are not implemented.

Test Plan:
- Reset with HRESETn=0, then release -> HREADYOUT=1, HRESP=0, HRDATA=0; all registers read back RESET_VAL.
- NONSEQ word write of 0xDEADBEEF to 0x04 (WAIT_CYCLES=0), then read 0x04 -> HRDATA=0xDEADBEEF in the read data phase with zero waits.
- Byte write 0x55 to 0x05 over 0xDEADBEEF, then word read 0x04 -> 0xDEAD55EF. Halfword write 0x1234 to 0x06 -> 0x123455EF.
- WAIT_CYCLES=3: word write -> HREADYOUT low for exactly 3 cycles, then high; the write commits at the last cycle. The next address phase is held off until then.
- With AHB_SLV_ERR_EN, write to 0x40 (NUM_REGS=16) or word write to 0x02:
  - required response: HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1;
  - registers unchanged.
  - Without the macro: one OKAY cycle, registers unchanged.
- Assert HRESETn low during the WAIT data phase of a write -> no commit; outputs are at reset values immediately (asynchronous).
